clock_set_ctrl: RTL and testbench

Mode/sequencing controller for the clock counter chain. Generates the 1 Hz enable that drives the seconds/minutes chain `enin`, and debounces the two front-panel buttons. Runs a RUN / SET_MIN / SET_HOUR state machine that emits single-cycle increment pulses (`inc`) to the minute and hour counters, with auto-repeat while a button is held. Sits between the board buttons and the counter chain; its mode and blink outputs also feed the display driver.

---
 rtl/clock_set_ctrl.sv | 143 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the clock counter chain: 1 Hz prescaler,
// front-panel button debounce, and the RUN / SET_MIN / SET_HOUR set sequence.
module clock_set_ctrl #(
  parameter int CNT_1HZ = 50000000,
  parameter int DEB_CYC = 500000,
  parameter int RPT_DLY = 50000000,
  parameter int RPT_PER = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       set_btn,
  output logic       en1hz,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hour_inc,
  output logic [1:0] mode,
  output logic       blink
);

  // state    | meaning
  // RUN      | normal timekeeping, en1hz pulses to the seconds chain
  // SET_MIN  | set button increments minutes, display blinks
  // SET_HOUR | set button increments hours, display blinks
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } state_t;

  localparam int PW = (CNT_1HZ > 1) ? $clog2(CNT_1HZ) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HW = $clog2(RPT_DLY + 1);
  localparam int RW = (RPT_PER > 1) ? $clog2(RPT_PER) : 1;

  state_t        state, next_state;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [1:0]    btn, s1, s2, deb, deb_d, press;
  logic [DW-1:0] dcnt [2];
  logic [HW-1:0] hcnt;
  logic [RW-1:0] rcnt;
  logic          mode_press, set_press, strobe, hold_clr;
  logic          min_nx, hour_nx;

  assign btn = {set_btn, mode_btn};

  // bit 0 = mode button, bit 1 = set button
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= '0;
      s2      <= '0;
      deb     <= '0;
      deb_d   <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYC - 1)) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign press      = deb & ~deb_d;
  assign mode_press = press[0];
  assign set_press  = press[1];
  assign tick       = (pcnt == PW'(CNT_1HZ - 1));

  always_comb begin
    next_state = state;
    min_nx     = 1'b0;
    hour_nx    = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) next_state = SET_MIN;
      end
      SET_MIN: begin
        if (mode_press)                next_state = SET_HOUR;
        else if (set_press || strobe)  min_nx     = 1'b1;
      end
      SET_HOUR: begin
        if (mode_press)                next_state = RUN;
        else if (set_press || strobe)  hour_nx    = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  // Hold time only accumulates while a set mode stays put with the button down
  assign hold_clr = !deb[1] || (state == RUN) || (next_state != state);
  assign strobe   = deb[1] && (hcnt == HW'(RPT_DLY)) && (rcnt == RW'(RPT_PER - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt <= '0;
      rcnt <= '0;
    end else if (hold_clr) begin
      hcnt <= '0;
      rcnt <= '0;
    end else if (hcnt != HW'(RPT_DLY)) begin
      hcnt <= hcnt + HW'(1);
    end else if (rcnt == RW'(RPT_PER - 1)) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      pcnt     <= '0;
      en1hz    <= 1'b0;
      sec_clr  <= 1'b0;
      min_inc  <= 1'b0;
      hour_inc <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state <= next_state;
      // Returning to RUN restarts the second so the first en1hz is a full period away
      if ((state == SET_HOUR && next_state == RUN) || tick) pcnt <= '0;
      else                                                   pcnt <= pcnt + PW'(1);
      en1hz    <= tick && (state == RUN);
      sec_clr  <= (state == RUN) && (next_state == SET_MIN);
      min_inc  <= min_nx;
      hour_inc <= hour_nx;
      blink    <= (state != RUN) && (pcnt < PW'(CNT_1HZ / 2));
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus pushes expected pulse cycles and
// per-cycle mode/blink levels; a negedge monitor pops and compares.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_btn = 1'b0;
  logic       set_btn = 1'b0;
  logic       en1hz, sec_clr, min_inc, hour_inc, blink;
  logic [1:0] mode;

  clock_set_ctrl #(
    .CNT_1HZ(10), .DEB_CYC(4), .RPT_DLY(20), .RPT_PER(5)
  ) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .set_btn(set_btn),
    .en1hz(en1hz), .sec_clr(sec_clr), .min_inc(min_inc), .hour_inc(hour_inc),
    .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] m;
    logic       b;
  } lv_t;

  int  q_en[$], q_clr[$], q_min[$], q_hr[$];
  lv_t q_lv[$];
  int  n_checks = 0;
  int  n_pass = 0;

  // expected-state model
  int         base = 0;
  int         m_cur = 0;
  int         pend_edge = -1;
  int         pend_mode = 0;
  bit         model_rst = 1'b1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  always @(negedge clk) begin
    lv_t t;
    int  h;
    if (q_lv.size() > 0 && q_lv[0].c <= cyc) begin
      t = q_lv.pop_front();
      chk("mode", int'(mode), int'(t.m));
      chk("blink", int'(blink), int'(t.b));
    end
    if (en1hz || (q_en.size() > 0 && q_en[0] < cyc)) begin
      h = (q_en.size() > 0) ? q_en.pop_front() : -1;
      chk("en1hz_cycle", en1hz ? cyc : -1, h);
    end
    if (sec_clr || (q_clr.size() > 0 && q_clr[0] < cyc)) begin
      h = (q_clr.size() > 0) ? q_clr.pop_front() : -1;
      chk("sec_clr_cycle", sec_clr ? cyc : -1, h);
    end
    if (min_inc || (q_min.size() > 0 && q_min[0] < cyc)) begin
      h = (q_min.size() > 0) ? q_min.pop_front() : -1;
      chk("min_inc_cycle", min_inc ? cyc : -1, h);
    end
    if (hour_inc || (q_hr.size() > 0 && q_hr[0] < cyc)) begin
      h = (q_hr.size() > 0) ? q_hr.pop_front() : -1;
      chk("hour_inc_cycle", hour_inc ? cyc : -1, h);
    end
  end

  // Predict levels/en1hz for the coming edge, then advance to the next negedge.
  task automatic step();
    int         e, p, mn;
    logic       bl, en;
    lv_t        t;
    e = cyc + 1;
    p = (cyc - base) % 10;
    if (model_rst) begin
      mn = 0; bl = 1'b0; en = 1'b0;
    end else begin
      mn = (pend_edge == e) ? pend_mode : m_cur;
      bl = (m_cur != 0) && (p < 5);
      en = (m_cur == 0) && (p == 9);
    end
    if (en) q_en.push_back(e);
    t.c = e; t.m = 2'(mn); t.b = bl;
    q_lv.push_back(t);
    if (model_rst || (m_cur == 2 && mn == 0)) base = e;
    if (model_rst) pend_edge = -1;
    m_cur = mn;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Clean press: raw level applied now reaches the FSM 6 edges later, acting on edge +7.
  task automatic hold(input logic m, input logic s, input int n, input int gap);
    int e;
    e = cyc;
    if (m) begin
      pend_edge = e + 7;
      pend_mode = (m_cur == 0) ? 1 : (m_cur == 1) ? 2 : 0;
      if (m_cur == 0) q_clr.push_back(e + 7);
    end else if (s && m_cur == 1) begin
      q_min.push_back(e + 7);
    end else if (s && m_cur == 2) begin
      q_hr.push_back(e + 7);
    end
    mode_btn = m;
    set_btn  = s;
    steps(n);
    mode_btn = 1'b0;
    set_btn  = 1'b0;
    steps(gap);
  endtask

  initial begin
    int e;
    // reset for three edges, then idle in RUN
    model_rst = 1'b1;
    steps(3);
    rst = 1'b1;
    model_rst = 1'b0;
    steps(35);

    // short mode-button glitches must be rejected
    for (int g = 0; g < 3; g++) begin
      mode_btn = 1'b1; steps(2);
      mode_btn = 1'b0; steps(4);
    end
    hold(1'b1, 1'b0, 10, 12);            // RUN -> SET_MIN

    for (int k = 0; k < 3; k++) hold(1'b0, 1'b1, 10, 12);
    hold(1'b1, 1'b0, 10, 12);            // SET_MIN -> SET_HOUR
    for (int k = 0; k < 2; k++) hold(1'b0, 1'b1, 10, 12);

    hold(1'b1, 1'b1, 10, 12);            // simultaneous: mode wins, back to RUN
    steps(25);

    hold(1'b1, 1'b0, 10, 12);            // RUN -> SET_MIN
    // auto-repeat: press, then strobes 25,30,..,45 cycles after debounced rise
    e = cyc;
    q_min.push_back(e + 7);
    for (int k = 0; k < 5; k++) q_min.push_back(e + 31 + 5 * k);
    set_btn = 1'b1;
    steps(46);
    set_btn = 1'b0;
    steps(15);

    // reset while set is held in SET_MIN
    e = cyc;
    q_min.push_back(e + 7);
    set_btn = 1'b1;
    steps(9);
    rst = 1'b0;
    model_rst = 1'b1;
    step();
    rst = 1'b1;
    model_rst = 1'b0;
    steps(20);
    set_btn = 1'b0;
    steps(25);

    chk("en1hz_left", q_en.size(), 0);
    chk("sec_clr_left", q_clr.size(), 0);
    chk("min_inc_left", q_min.size(), 0);
    chk("hour_inc_left", q_hr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
